// File: rtl/vlsu_addr_sequencer.sv
// VLSU address sequencer: issues one OBI word request per beat for a vector
// load/store, generating word address and byte enables from vl/vsew/stride.
module vlsu_addr_sequencer #(
    parameter int ADDR_W = 32,
    parameter int VL_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        vsew_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic              strided_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_be_o,
    input  logic              data_rvalid_i,
    output logic              beat_valid_o,
    output logic [VL_W-1:0]   beat_elem_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [1:0]        r_vsew;
    logic [VL_W-1:0]   r_vl;
    logic [VL_W-1:0]   r_elem;
    logic              r_strided;
    logic              r_err;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_addr;

    logic              w_start_strided;
    logic              w_start_illegal;
    logic              w_start_empty;
    logic [2:0]        w_epb;
    logic [VL_W:0]     w_elem_next;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_next_misaligned;
    logic [VL_W+2:0]   w_rem_bytes;
    logic [3:0]        w_be;
    logic              w_accept;

    function automatic logic f_misaligned(input logic [1:0] lsb, input logic [1:0] sew);
        case (sew)
            2'd0:    f_misaligned = 1'b0;
            2'd1:    f_misaligned = lsb[0];
            default: f_misaligned = |lsb;
        endcase
    endfunction

    // A zero stride degenerates to unit stride, including its base alignment rule.
    assign w_start_strided = strided_i && (stride_i != '0);
    assign w_start_illegal = (vsew_i == 2'd3)
                          || (!w_start_strided && (|base_addr_i[1:0]))
                          || (w_start_strided && f_misaligned(base_addr_i[1:0], vsew_i));
    assign w_start_empty   = (vl_i == '0);

    assign w_epb       = r_strided ? 3'd1 : (3'd4 >> r_vsew);
    assign w_elem_next = {1'b0, r_elem} + {{(VL_W-2){1'b0}}, w_epb};
    assign w_last_beat = (w_elem_next >= {1'b0, r_vl});
    assign w_addr_next = r_strided ? (r_addr + r_stride) : (r_addr + ADDR_W'(4));
    assign w_next_misaligned = r_strided && f_misaligned(w_addr_next[1:0], r_vsew);
    assign w_accept    = (r_state == S_WAIT) && data_rvalid_i;

    // Bytes still owed; only the final unit-stride beat ever drops below a full word.
    assign w_rem_bytes = {3'b000, r_vl - r_elem} << r_vsew;

    always_comb begin
        w_be = 4'h0;
        if (r_strided) begin
            case (r_vsew)
                2'd0:    w_be = 4'b0001 << r_addr[1:0];
                2'd1:    w_be = 4'b0011 << r_addr[1:0];
                default: w_be = 4'b1111 << r_addr[1:0];
            endcase
        end else if (|w_rem_bytes[VL_W+2:2]) begin
            w_be = 4'hF;
        end else begin
            w_be = (4'b0001 << w_rem_bytes[1:0]) - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = (w_start_illegal || w_start_empty) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    w_next_state = (w_last_beat || w_next_misaligned) ? S_DONE : S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (r_state != S_IDLE);
        done_o       = (r_state == S_DONE);
        err_o        = (r_state == S_DONE) && r_err;
        data_req_o   = (r_state == S_REQ);
        data_addr_o  = '0;
        data_be_o    = '0;
        beat_valid_o = w_accept;
        beat_elem_o  = '0;
        if (r_state == S_REQ) begin
            data_addr_o = {r_addr[ADDR_W-1:2], 2'b00};
            data_be_o   = w_be;
        end
        if (w_accept) begin
            beat_elem_o = r_elem;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsew    <= '0;
            r_vl      <= '0;
            r_elem    <= '0;
            r_strided <= 1'b0;
            r_err     <= 1'b0;
            r_stride  <= '0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_vsew    <= vsew_i;
                        r_vl      <= vl_i;
                        r_elem    <= '0;
                        r_strided <= w_start_strided;
                        r_stride  <= stride_i;
                        r_addr    <= base_addr_i;
                        r_err     <= w_start_illegal;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        r_elem <= w_elem_next[VL_W-1:0];
                        r_addr <= w_addr_next;
                        r_err  <= !w_last_beat && w_next_misaligned;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vlsu_addr_sequencer.sv
// Bench for vlsu_addr_sequencer: directed scenarios plus randomized sequences
// checked against an arithmetic per-beat reference model.
module tb_vlsu_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  vsew;
    logic [4:0]  vl;
    logic        strided;
    logic [31:0] stride;
    logic [31:0] base;
    logic        busy_o, done_o, err_o, data_req_o, beat_valid_o;
    logic        gnt, rvalid;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [4:0]  beat_elem_o;

    int checks = 0;
    int errors = 0;
    int obs_busy;

    logic [31:0] q_addr[$];
    logic [3:0]  q_be[$];
    int          q_elem[$];
    bit          m_err;

    always #5 clk = ~clk;

    vlsu_addr_sequencer #(.ADDR_W(32), .VL_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .vsew_i(vsew), .vl_i(vl),
        .strided_i(strided), .stride_i(stride), .base_addr_i(base),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .data_req_o(data_req_o), .data_gnt_i(gnt), .data_addr_o(data_addr_o),
        .data_be_o(data_be_o), .data_rvalid_i(rvalid),
        .beat_valid_o(beat_valid_o), .beat_elem_o(beat_elem_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (busy_o === 1'b1) obs_busy++;
    endtask

    // Reference: list of expected beats computed directly from the access rules.
    task automatic build_model(input logic [1:0] sew, input int unsigned n, input bit str,
                               input logic [31:0] strd, input logic [31:0] b);
        int unsigned size, epb, nb, rem;
        logic [31:0] a;
        q_addr.delete(); q_be.delete(); q_elem.delete();
        m_err = 1'b0;
        if (sew == 2'd3) begin
            m_err = 1'b1;
            return;
        end
        size = 1 << sew;
        if (!str || strd == 32'd0) begin
            if (b[1:0] != 2'b00) begin
                m_err = 1'b1;
                return;
            end
            epb = 4 / size;
            nb  = (n + epb - 1) / epb;
            for (int unsigned k = 0; k < nb; k++) begin
                rem = (n - k * epb) * size;
                q_addr.push_back(b + 32'(4 * k));
                q_be.push_back(rem >= 4 ? 4'hF : 4'((1 << rem) - 1));
                q_elem.push_back(int'(k * epb));
            end
        end else begin
            for (int unsigned e = 0; e < n; e++) begin
                a = b + strd * 32'(e);
                if ((a & 32'(size - 1)) != 32'd0) begin
                    m_err = 1'b1;
                    return;
                end
                q_addr.push_back({a[31:2], 2'b00});
                q_be.push_back(4'(((1 << size) - 1) << a[1:0]));
                q_elem.push_back(int'(e));
            end
        end
    endtask

    // Launches one sequence and plays memory; stall_beat/stall_len force a grant stall.
    task automatic run_seq(input string name, input logic [1:0] sew, input logic [4:0] n,
                           input bit str, input logic [31:0] strd, input logic [31:0] b,
                           input bit rnd_dly, input int stall_beat, input int stall_len);
        int gd, rd, nexp, exp_cyc;
        build_model(sew, int'(n), str, strd, b);
        nexp    = q_addr.size();
        exp_cyc = 1;
        @(negedge clk);
        start = 1'b1; vsew = sew; vl = n; strided = str; stride = strd; base = b;
        obs_busy = 0;
        step();
        start = 1'b0; vsew = 2'($urandom); vl = 5'($urandom); strided = 1'($urandom);
        stride = $urandom; base = $urandom;
        for (int k = 0; k < nexp; k++) begin
            chk($sformatf("%s.b%0d.req", name, k), 32'(data_req_o), 32'd1);
            chk($sformatf("%s.b%0d.addr", name, k), data_addr_o, q_addr[k]);
            chk($sformatf("%s.b%0d.be", name, k), 32'(data_be_o), 32'(q_be[k]));
            gd = (k == stall_beat) ? stall_len : (rnd_dly ? int'($urandom_range(0, 3)) : 0);
            rd = rnd_dly ? int'($urandom_range(0, 3)) : 0;
            exp_cyc += 2 + gd + rd;
            for (int j = 0; j < gd; j++) begin
                step();
                chk($sformatf("%s.b%0d.stall_req", name, k), 32'(data_req_o), 32'd1);
                chk($sformatf("%s.b%0d.stall_addr", name, k), data_addr_o, q_addr[k]);
                chk($sformatf("%s.b%0d.stall_be", name, k), 32'(data_be_o), 32'(q_be[k]));
            end
            gnt = 1'b1;
            step();
            gnt = 1'b0;
            chk($sformatf("%s.b%0d.wait_req", name, k), 32'(data_req_o), 32'd0);
            for (int j = 0; j < rd; j++) begin
                step();
                chk($sformatf("%s.b%0d.idle_beat", name, k), 32'(beat_valid_o), 32'd0);
            end
            rvalid = 1'b1;
            #1;
            chk($sformatf("%s.b%0d.beat_valid", name, k), 32'(beat_valid_o), 32'd1);
            chk($sformatf("%s.b%0d.beat_elem", name, k), 32'(beat_elem_o), 32'(q_elem[k]));
            step();
            rvalid = 1'b0;
        end
        chk({name, ".done"}, 32'(done_o), 32'd1);
        chk({name, ".err"}, 32'(err_o), 32'(m_err));
        chk({name, ".done_req"}, 32'(data_req_o), 32'd0);
        step();
        chk({name, ".done_clear"}, 32'(done_o), 32'd0);
        chk({name, ".idle_busy"}, 32'(busy_o), 32'd0);
        chk({name, ".busy_cycles"}, 32'(obs_busy), 32'(exp_cyc));
    endtask

    initial begin
        logic [1:0]  r_sew;
        logic [4:0]  r_vl;
        bit          r_str;
        logic [31:0] r_stride, r_base, r_tmp;
        int          sz;

        rst = 1'b1; start = 1'b0; vsew = '0; vl = '0; strided = 1'b0;
        stride = '0; base = '0; gnt = 1'b0; rvalid = 1'b0; obs_busy = 0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(busy_o), 32'd0);
        chk("reset.req", 32'(data_req_o), 32'd0);
        chk("reset.done", 32'(done_o), 32'd0);
        chk("reset.addr", data_addr_o, 32'd0);
        rst = 1'b0;

        run_seq("unit_word",   2'd2, 5'd4, 1'b0, 32'd0, 32'h100, 1'b0, -1, 0);
        run_seq("unit_byte",   2'd0, 5'd6, 1'b0, 32'd0, 32'h200, 1'b0, -1, 0);
        run_seq("strided_hw",  2'd1, 5'd3, 1'b1, 32'd6, 32'h40,  1'b0, -1, 0);
        run_seq("gnt_stall",   2'd2, 5'd4, 1'b0, 32'd0, 32'h100, 1'b0, 1, 3);
        run_seq("vl_zero",     2'd2, 5'd0, 1'b0, 32'd0, 32'h100, 1'b0, -1, 0);
        run_seq("vsew3",       2'd3, 5'd4, 1'b0, 32'd0, 32'h100, 1'b0, -1, 0);
        run_seq("str_misalgn", 2'd2, 5'd3, 1'b1, 32'd2, 32'h80,  1'b0, -1, 0);
        run_seq("unit_misalgn",2'd0, 5'd5, 1'b0, 32'd0, 32'h81,  1'b0, -1, 0);
        run_seq("stride_zero", 2'd1, 5'd5, 1'b1, 32'd0, 32'h300, 1'b0, -1, 0);
        run_seq("neg_stride",  2'd2, 5'd4, 1'b1, 32'hFFFF_FFF8, 32'h10, 1'b1, -1, 0);

        // Reset while waiting on beat 2's response.
        @(negedge clk);
        start = 1'b1; vsew = 2'd2; vl = 5'd4; strided = 1'b0; base = 32'h100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            gnt = 1'b1; @(negedge clk); gnt = 1'b0;
            rvalid = 1'b1; @(negedge clk); rvalid = 1'b0;
        end
        chk("rst_mid.b2_addr", data_addr_o, 32'h108);
        gnt = 1'b1; @(negedge clk); gnt = 1'b0;
        chk("rst_mid.in_wait", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.busy", 32'(busy_o), 32'd0);
        chk("rst_mid.req", 32'(data_req_o), 32'd0);
        chk("rst_mid.done", 32'(done_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.no_done", 32'(done_o), 32'd0);
        run_seq("after_rst", 2'd2, 5'd4, 1'b0, 32'd0, 32'h100, 1'b0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            r_sew = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_vl  = 5'($urandom_range(0, 16));
            if (r_sew == 2'd3 && r_vl == 5'd0) r_vl = 5'd1;
            r_str = 1'($urandom);
            sz    = 1 << (r_sew == 2'd3 ? 2 : r_sew);
            case ($urandom_range(0, 3))
                0:       r_stride = 32'd0;
                1:       r_stride = 32'(($urandom_range(0, 16) - 8) * sz);
                2:       r_stride = $urandom;
                default: r_stride = 32'($urandom_range(0, 9)) - 32'd4;
            endcase
            r_tmp  = $urandom;
            r_base = ($urandom_range(0, 3) == 0) ? r_tmp : {r_tmp[31:2], 2'b00};
            run_seq($sformatf("rand%0d", t), r_sew, r_vl, r_str, r_stride, r_base, 1'b1, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vlsu_addr_sequencer.md
Name: vlsu_addr_sequencer

Overview:
- Sequences vector load/store memory traffic for the VLSU.
- Given vl, vsew, base address and an optional stride, it issues one word request per beat on an OBI-style req/gnt/rvalid interface and generates the word address and byte enables for each beat.
- It reports each returned beat to the register-write path and pulses done when the last response arrives.
- It sits between the VLSU decode/control logic and the data memory port.

Parameters:
- ADDR_W, 32, width of addresses and stride.
- VL_W, 5, width of vl_i and element counters; legal vl is 0..16.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  launches a sequence; sampled only in IDLE.
- vsew_i  in  2  element width: 0=8b, 1=16b, 2=32b, 3=illegal.
- vl_i  in  VL_W  number of elements.
- strided_i  in  1  1 selects a strided access.
- stride_i  in  ADDR_W  byte stride, two's complement.
- base_addr_i  in  ADDR_W  byte address of element 0.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at sequence end.
- err_o  out  1  one-cycle pulse, coincident with done_o, on an illegal configuration.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_addr_o  out  ADDR_W  word-aligned request address.
- data_be_o  out  4  byte enables.
- data_rvalid_i  in  1  read-data or write-ack response.
- beat_valid_o  out  1  pulses with each accepted response.
- beat_elem_o  out  VL_W  index of the first element covered by the current beat.

Behaviour:
- Configuration capture: start_i in IDLE latches vsew, vl, strided, stride and base. Inputs are ignored while busy.
- Effective stride: strided_i=1 with stride_i=0 is treated as unit stride.
- Elements per beat (epb):
  - Unit stride: 4>>vsew.
  - Strided: 1.
- Beats needed: ceil(vl/epb), computed as (vl>>log2(epb)) plus 1 if any truncated bit is set.
- Unit-stride addressing:
  - Beat addr = base + 4*beat; data_addr_o = that value with bits [1:0] forced to 0.
  - be = 4'hF, except on the final beat where only the remaining (vl - elem)*size bytes are enabled from bit 0. Example: vsew=0, vl=6 gives beat 1 be=4'b0011.
- Strided addressing:
  - Element addr = base + stride*elem, kept as a running sum (no multiplier), wrapping modulo 2^ADDR_W.
  - data_addr_o = addr with [1:0] forced to 0.
  - be = size mask (1, 3 or F) << addr[1:0].
- Illegal configurations: vsew=3, a unit-stride base with base[1:0]!=0, or a strided element misaligned for its size. The sequence issues no request for that beat, goes to DONE, and pulses err_o with done_o. For misaligned strided elements, earlier beats have already completed.
- State machine:
  - IDLE: outputs low. On start_i go to REQ, or to DONE if vl=0 or the configuration is illegal.
  - REQ: data_req_o=1, with addr and be stable until data_gnt_i. On gnt go to WAIT.
  - WAIT: data_req_o=0. On data_rvalid_i, pulse beat_valid_o with beat_elem_o = current element, advance the element counter by epb, then go to DONE if this was the last beat, else REQ.
  - DONE: done_o=1 for one cycle, then IDLE.
- Outstanding requests: at most one; the next req is raised the cycle after rvalid.
- Minimum latency per beat: 2 cycles (REQ with same-cycle gnt, then WAIT with rvalid).
- Simultaneous events:
  - rvalid arriving in REQ is ignored; the bench must not drive it.
  - start_i held high in DONE does not retrigger; it is sampled again in IDLE.
- Reset: rst_i asserted in any state returns to IDLE on the next edge. All outputs and counters are 0, the in-flight request is dropped, and no done_o is produced.

Test Plan:
- Unit stride word: vsew=2, vl=4, base=0x100, gnt and rvalid immediate -> 4 beats at addrs 0x100, 0x104, 0x108, 0x10C, all be=F, beat_elem 0,1,2,3; done_o 1 cycle after the 4th rvalid; busy_o for 9 cycles.
- Unit stride byte, partial: vsew=0, vl=6, base=0x200 -> 2 beats at 0x200 (be=F) and 0x204 (be=0011); beat_elem 0,4.
- Strided halfword: vsew=1, vl=3, stride=6, base=0x40 -> addrs 0x40 (be=0011), 0x44 (be=1100), 0x4C (be=0011).
- Grant stall: same as the first scenario with gnt held low 3 cycles on beat 1 -> data_req_o, addr 0x104 and be stable through the stall; no extra requests.
- Edge configurations:
  - vl=0 -> done_o the cycle after start, no data_req_o.
  - vsew=3 -> done_o and err_o together, no data_req_o.
  - strided vsew=2 with stride=2 -> beat 0 completes, then err_o with no beat 1 request.
- Reset mid-sequence: assert rst_i in WAIT of beat 2 -> next cycle busy_o=0, data_req_o=0, no done_o; a fresh start then restarts from beat 0.
